// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, round functions, byte reversal and miner state encoding
package sha256_pkg;

    typedef logic [0:7][31:0]  hash_t;
    typedef logic [0:15][31:0] block_t;

    typedef enum logic [2:0] {IDLE, MID, B2, H2, DONE} state_e;

    localparam hash_t IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [31:0] byte_reverse32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    function automatic logic [255:0] byte_reverse256(input logic [255:0] x);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
        return r;
    endfunction

    // Second header block: bytes 64..75, little-endian nonce, padding for a 640-bit message
    function automatic block_t b2_block(input logic [95:0] tail, input logic [31:0] nonce);
        return {tail, byte_reverse32(nonce), 32'h80000000, 288'd0, 64'd640};
    endfunction

    function automatic block_t h2_block(input hash_t d);
        return {d, 32'h80000000, 160'd0, 64'd256};
    endfunction

endpackage

// File: rtl/sha256_rounds.sv
// sha256_rounds: combinational ROUNDS_PER_CYCLE SHA-256 rounds with a rolling 16-word schedule
module sha256_rounds
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic [5:0] t0,
    input  hash_t      v,
    input  block_t     w,
    output hash_t      v_next,
    output block_t     w_next
);
    hash_t       a;
    block_t      s;
    logic [31:0] t1, t2, nw;

    // s[0] is always W[t]; the word shifted in is W[t+16]
    always_comb begin
        a = v;
        s = w;
        t1 = '0;
        t2 = '0;
        nw = '0;
        for (int r = 0; r < ROUNDS_PER_CYCLE; r++) begin
            t1 = a[7] + bsig1(a[4]) + ch(a[4], a[5], a[6]) + K[t0 + 6'(r)] + s[0];
            t2 = bsig0(a[0]) + maj(a[0], a[1], a[2]);
            nw = ssig1(s[14]) + s[9] + ssig0(s[1]) + s[0];
            a = {t1 + t2, a[0:2], a[3] + t1, a[4:6]};
            s = {s[1:15], nw};
        end
        v_next = a;
        w_next = s;
    end
endmodule

// File: rtl/sha256_nonce_miner.sv
// sha256_nonce_miner: double-SHA-256 nonce sweep with reused midstate and target compare
module sha256_nonce_miner
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [639:0] blockHeader,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_count,
    input  logic [255:0] target,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [31:0]  found_nonce,
    output logic [255:0] digest
);
    localparam int C  = 64 / ROUNDS_PER_CYCLE;
    localparam int LR = $clog2(ROUNDS_PER_CYCLE);

    if (ROUNDS_PER_CYCLE != 1 && ROUNDS_PER_CYCLE != 2 && ROUNDS_PER_CYCLE != 4 && ROUNDS_PER_CYCLE != 8) begin : g_bad_rounds
        $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_e       st;
    logic [6:0]   cnt;
    logic [5:0]   t0;
    hash_t        v, v_src, v_nx, mid, sum;
    block_t       w, w_src, w_nx;
    logic [95:0]  tail;
    logic [31:0]  nonce, rem;
    logic [255:0] tgt;
    logic         hit;
    logic         unused_nonce_field;

    assign unused_nonce_field = ^blockHeader[31:0];
    assign t0 = cnt[5:0] << LR;

    // The first MID round group runs on the start edge straight from the inputs
    assign v_src = st == IDLE ? IV : v;
    assign w_src = st == IDLE ? blockHeader[639:128] : w;

    sha256_rounds #(.ROUNDS_PER_CYCLE(ROUNDS_PER_CYCLE)) u_rounds (
        .t0(t0),
        .v(v_src),
        .w(w_src),
        .v_next(v_nx),
        .w_next(w_nx)
    );

    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++) sum[i] = (st == B2 ? mid[i] : IV[i]) + v[i];
    end

    assign hit = byte_reverse256(sum) <= tgt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= IDLE;
            cnt         <= '0;
            v           <= '0;
            w           <= '0;
            mid         <= '0;
            tail        <= '0;
            nonce       <= '0;
            rem         <= '0;
            tgt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            found_nonce <= '0;
            digest      <= '0;
        end else begin
            done <= 1'b0;
            if (busy && abort) begin
                st   <= IDLE;
                cnt  <= '0;
                busy <= 1'b0;
            end else if (st == IDLE) begin
                if (start && !abort) begin
                    tail  <= blockHeader[127:32];
                    nonce <= nonce_start;
                    rem   <= nonce_count;
                    tgt   <= target;
                    v     <= v_nx;
                    w     <= w_nx;
                    if (nonce_count == 32'd0) begin
                        st          <= DONE;
                        done        <= 1'b1;
                        found       <= 1'b0;
                        found_nonce <= nonce_start;
                    end else begin
                        st   <= MID;
                        cnt  <= 7'd1;
                        busy <= 1'b1;
                    end
                end
            end else if (st == DONE) begin
                st <= IDLE;
            end else if (cnt != 7'(C)) begin
                v   <= v_nx;
                w   <= w_nx;
                cnt <= cnt + 7'd1;
            end else begin
                cnt <= '0;
                if (st == MID) begin
                    mid <= sum;
                    v   <= sum;
                    w   <= b2_block(tail, nonce);
                    st  <= B2;
                end else if (st == B2) begin
                    v  <= IV;
                    w  <= h2_block(sum);
                    st <= H2;
                end else if (hit || rem == 32'd1) begin
                    st          <= DONE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    found       <= hit;
                    found_nonce <= nonce;
                    digest      <= sum;
                end else begin
                    nonce <= nonce + 32'd1;
                    rem   <= rem - 32'd1;
                    v     <= mid;
                    w     <= b2_block(tail, nonce + 32'd1);
                    st    <= B2;
                end
            end
        end
    end
endmodule

// File: tb/tb_sha256_nonce_miner.sv
// tb_sha256_nonce_miner: directed checks of sweep, target boundary, wrap, abort and reset
module tb_sha256_nonce_miner;
    localparam logic [639:0] HDR = 640'h0100000081cd02ab7e569e8bcd9317e2fe99f2de44d49ab2b8851ba4a308000000000000e320b6c2fffc8d750423db8b1eb942ae710e951ed797f7affc8892b0f1fc122bc7f5d74df2b9441a42a14695;
    localparam logic [255:0] D1  = 256'h1dbd981fe6985776b644b173a4d0385ddc1aa2a829688d1e0000000000000000;
    localparam logic [255:0] TEQ = 256'h00000000000000001e8d6829a8a21adc5d38d0a473b144b6765798e61f98bd1d;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [2:0]   start = '0;
    logic [2:0]   abort = '0;
    logic [639:0] hdr = HDR;
    logic [31:0]  ns = '0;
    logic [31:0]  nc = '0;
    logic [255:0] tg = '0;
    logic [2:0]   busy, done, found;
    logic [31:0]  fnonce [3];
    logic [255:0] dig [3];
    int           compared = 0;
    int           mismatched = 0;

    always #5 clk = ~clk;

    // Instances 0, 1, 2 run 1, 4 and 8 rounds per cycle
    for (genvar g = 0; g < 3; g++) begin : g_dut
        sha256_nonce_miner #(.ROUNDS_PER_CYCLE(g == 0 ? 1 : g == 1 ? 4 : 8)) dut (
            .clk(clk),
            .reset(reset),
            .start(start[g]),
            .abort(abort[g]),
            .blockHeader(hdr),
            .nonce_start(ns),
            .nonce_count(nc),
            .target(tg),
            .busy(busy[g]),
            .done(done[g]),
            .found(found[g]),
            .found_nonce(fnonce[g]),
            .digest(dig[g])
        );
    end

    task automatic start_job(input int d, input logic [31:0] s, input logic [31:0] n, input logic [255:0] t);
        @(negedge clk);
        ns = s;
        nc = n;
        tg = t;
        start[d] = 1'b1;
        @(posedge clk);
        #1 start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int from, output int lat, output int bcnt);
        lat = -1;
        bcnt = 0;
        for (int k = from; k <= 1000 && lat < 0; k++) begin
            @(negedge clk);
            if (done[d]) lat = k;
            else if (busy[d]) bcnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            compared += 3;
            if ({busy[d], done[d], found[d]} !== 3'b000) begin mismatched++; $display("FAIL reset_flags[%0d]: got %b want 000", d, {busy[d], done[d], found[d]}); end
            if (fnonce[d] !== 32'd0) begin mismatched++; $display("FAIL reset_nonce[%0d]: got %h want 0", d, fnonce[d]); end
            if (dig[d] !== 256'd0) begin mismatched++; $display("FAIL reset_digest[%0d]: got %h want 0", d, dig[d]); end
        end
        reset = 1'b1;
    endtask

    task automatic test_single();
        int lat, bcnt;
        start_job(0, 32'h9546a142, 32'd1, '1);
        wait_done(0, 1, lat, bcnt);
        compared += 6;
        if (lat !== 195) begin mismatched++; $display("FAIL single_latency: got %0d want 195", lat); end
        if (bcnt !== 194) begin mismatched++; $display("FAIL single_busy_cycles: got %0d want 194", bcnt); end
        if (busy[0] !== 1'b0) begin mismatched++; $display("FAIL single_busy_in_done: got %b want 0", busy[0]); end
        if (found[0] !== 1'b1) begin mismatched++; $display("FAIL single_found: got %b want 1", found[0]); end
        if (fnonce[0] !== 32'h9546a142) begin mismatched++; $display("FAIL single_nonce: got %h want 9546a142", fnonce[0]); end
        if (dig[0] !== D1) begin mismatched++; $display("FAIL single_digest: got %h want %h", dig[0], D1); end
    endtask

    task automatic test_abort();
        int lat, bcnt;
        start_job(0, 32'h9546a142, 32'd1, '1);
        repeat (100) @(negedge clk);
        abort[0] = 1'b1;
        @(posedge clk);
        #1 abort[0] = 1'b0;
        @(negedge clk);
        compared += 4;
        if ({busy[0], done[0]} !== 2'b00) begin mismatched++; $display("FAIL abort_busy_done: got %b want 00", {busy[0], done[0]}); end
        if (found[0] !== 1'b1) begin mismatched++; $display("FAIL abort_found_kept: got %b want 1", found[0]); end
        if (fnonce[0] !== 32'h9546a142) begin mismatched++; $display("FAIL abort_nonce_kept: got %h want 9546a142", fnonce[0]); end
        if (dig[0] !== D1) begin mismatched++; $display("FAIL abort_digest_kept: got %h want %h", dig[0], D1); end
        start_job(0, 32'h9546a140, 32'd3, TEQ);
        wait_done(0, 1, lat, bcnt);
        compared += 4;
        if (lat !== 455) begin mismatched++; $display("FAIL restart_latency: got %0d want 455", lat); end
        if (found[0] !== 1'b1) begin mismatched++; $display("FAIL restart_found: got %b want 1", found[0]); end
        if (fnonce[0] !== 32'h9546a142) begin mismatched++; $display("FAIL restart_nonce: got %h want 9546a142", fnonce[0]); end
        if (dig[0] !== D1) begin mismatched++; $display("FAIL restart_digest: got %h want %h", dig[0], D1); end
    endtask

    task automatic test_empty();
        int lat, bcnt;
        start_job(0, 32'h12345678, 32'd0, '1);
        wait_done(0, 1, lat, bcnt);
        compared += 5;
        if (lat !== 1) begin mismatched++; $display("FAIL empty_latency: got %0d want 1", lat); end
        if (busy[0] !== 1'b0) begin mismatched++; $display("FAIL empty_busy: got %b want 0", busy[0]); end
        if (found[0] !== 1'b0) begin mismatched++; $display("FAIL empty_found: got %b want 0", found[0]); end
        if (fnonce[0] !== 32'h12345678) begin mismatched++; $display("FAIL empty_nonce: got %h want 12345678", fnonce[0]); end
        if (dig[0] !== D1) begin mismatched++; $display("FAIL empty_digest_kept: got %h want %h", dig[0], D1); end
        @(negedge clk);
        compared++;
        if ({busy[0], done[0]} !== 2'b00) begin mismatched++; $display("FAIL empty_after: got %b want 00", {busy[0], done[0]}); end
    endtask

    task automatic test_boundary_equal();
        int lat, bcnt;
        start_job(1, 32'h9546a140, 32'd4, TEQ);
        repeat (40) @(negedge clk);
        ns = 32'h0;
        nc = 32'd0;
        tg = '1;
        start[1] = 1'b1;
        @(posedge clk);
        #1 start[1] = 1'b0;
        wait_done(1, 41, lat, bcnt);
        compared += 5;
        if (lat !== 119) begin mismatched++; $display("FAIL equal_latency: got %0d want 119", lat); end
        if (bcnt !== 78) begin mismatched++; $display("FAIL equal_busy_cycles: got %0d want 78", bcnt); end
        if (found[1] !== 1'b1) begin mismatched++; $display("FAIL equal_found: got %b want 1", found[1]); end
        if (fnonce[1] !== 32'h9546a142) begin mismatched++; $display("FAIL equal_nonce: got %h want 9546a142", fnonce[1]); end
        if (dig[1] !== D1) begin mismatched++; $display("FAIL equal_digest: got %h want %h", dig[1], D1); end
    endtask

    task automatic test_boundary_below();
        int lat, bcnt;
        start_job(1, 32'h9546a140, 32'd4, TEQ - 256'd1);
        wait_done(1, 1, lat, bcnt);
        compared += 5;
        if (lat !== 153) begin mismatched++; $display("FAIL below_latency: got %0d want 153", lat); end
        if (bcnt !== 152) begin mismatched++; $display("FAIL below_busy_cycles: got %0d want 152", bcnt); end
        if (busy[1] !== 1'b0) begin mismatched++; $display("FAIL below_busy_in_done: got %b want 0", busy[1]); end
        if (found[1] !== 1'b0) begin mismatched++; $display("FAIL below_found: got %b want 0", found[1]); end
        if (fnonce[1] !== 32'h9546a143) begin mismatched++; $display("FAIL below_nonce: got %h want 9546a143", fnonce[1]); end
    endtask

    task automatic test_wrap();
        int lat, bcnt;
        start_job(2, 32'hffffffff, 32'd2, '0);
        wait_done(2, 1, lat, bcnt);
        compared += 4;
        if (lat !== 45) begin mismatched++; $display("FAIL wrap_latency: got %0d want 45", lat); end
        if (bcnt !== 44) begin mismatched++; $display("FAIL wrap_busy_cycles: got %0d want 44", bcnt); end
        if (found[2] !== 1'b0) begin mismatched++; $display("FAIL wrap_found: got %b want 0", found[2]); end
        if (fnonce[2] !== 32'h00000000) begin mismatched++; $display("FAIL wrap_nonce: got %h want 00000000", fnonce[2]); end
    endtask

    task automatic test_reset_mid();
        start_job(0, 32'h9546a142, 32'd1, '1);
        repeat (50) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        compared += 5;
        if ({busy[0], done[0], found[0]} !== 3'b000) begin mismatched++; $display("FAIL midreset_flags: got %b want 000", {busy[0], done[0], found[0]}); end
        if (fnonce[0] !== 32'd0) begin mismatched++; $display("FAIL midreset_nonce: got %h want 0", fnonce[0]); end
        if (dig[0] !== 256'd0) begin mismatched++; $display("FAIL midreset_digest: got %h want 0", dig[0]); end
        if (fnonce[1] !== 32'd0) begin mismatched++; $display("FAIL midreset_idle_nonce: got %h want 0", fnonce[1]); end
        if (dig[1] !== 256'd0) begin mismatched++; $display("FAIL midreset_idle_digest: got %h want 0", dig[1]); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_abort();
        test_empty();
        test_boundary_equal();
        test_boundary_below();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
